// File: rtl/fetch_buffer.sv
// fetch_buffer: circular FIFO of fetch bundles between fetch and decode.
// Back-pressures fetch via stall; a redirect flush empties the buffer.
module fetch_buffer #(
  parameter int FETCH_WIDTH     = 2,
  parameter int INST_ADDR_WIDTH = 10,
  parameter int DEPTH           = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [FETCH_WIDTH-1:0][31:0]     in_inst,
  input  logic [INST_ADDR_WIDTH-1:0]       in_pc,
  output logic                             stall,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [FETCH_WIDTH-1:0][31:0]     out_inst,
  output logic [INST_ADDR_WIDTH-1:0]       out_pc,
  output logic [INST_ADDR_WIDTH-1:0]       out_pc_plus_4,
  output logic [$clog2(DEPTH):0]           occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [FETCH_WIDTH-1:0][31:0] mem_inst [DEPTH];
  logic [INST_ADDR_WIDTH-1:0]   mem_pc   [DEPTH];
  logic [PW-1:0]                head;
  logic [PW-1:0]                tail;
  logic [CW-1:0]                count;
  logic                         push;
  logic                         pop;

  // Handshake decode; stall ignores out_ready so a full buffer
  // always refuses, even when a pop happens in the same cycle.
  always_comb begin
    stall     = (count == CW'(DEPTH)) | flush;
    out_valid = (count != '0);
    push      = in_valid & ~stall;
    pop       = out_valid & out_ready & ~flush;
  end

  // Head read, gated to zero when empty so stale entries never leak.
  always_comb begin
    out_inst      = '0;
    out_pc        = '0;
    if (out_valid) begin
      out_inst = mem_inst[head];
      out_pc   = mem_pc[head];
    end
    out_pc_plus_4 = out_pc + INST_ADDR_WIDTH'(4);
    occupancy     = count;
  end

  // Pointers and count; flush wins over push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else if (push) begin
      mem_inst[tail] <= in_inst;
      mem_pc[tail]   <= in_pc;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed plus random stimulus against a queue
// model of the fetch buffer, checked every cycle on the falling edge.
module tb_fetch_buffer;

  localparam int FW = 2;
  localparam int AW = 10;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                in_valid = 1'b0;
  logic [FW-1:0][31:0] in_inst = '0;
  logic [AW-1:0]       in_pc = '0;
  logic                flush = 1'b0;
  logic                out_ready = 1'b0;
  logic                stall;
  logic                out_valid;
  logic [FW-1:0][31:0] out_inst;
  logic [AW-1:0]       out_pc;
  logic [AW-1:0]       out_pc_plus_4;
  logic [CW-1:0]       occupancy;

  fetch_buffer #(
    .FETCH_WIDTH(FW), .INST_ADDR_WIDTH(AW), .DEPTH(D)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
    .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc),
    .out_pc_plus_4(out_pc_plus_4), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [FW*32-1:0] inst;
    logic [AW-1:0]    pc;
  } ent_t;

  ent_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model and monitor: compare outputs against the queue
  // head, then apply what the coming rising edge will do.
  always @(negedge clk) begin
    if (!reset) begin : mon
      automatic int sz = q.size();
      automatic logic [AW-1:0] epc;
      automatic bit do_pop;
      automatic bit do_push;
      chk("stall", stall, (sz == D) || flush);
      chk("occupancy", occupancy, sz);
      chk("out_valid", out_valid, sz != 0);
      if (sz != 0) begin
        epc = q[0].pc + AW'(4);
        chk("out_inst", out_inst, q[0].inst);
        chk("out_pc", out_pc, q[0].pc);
        chk("out_pc_plus_4", out_pc_plus_4, epc);
      end else begin
        chk("out_inst_empty", out_inst, 0);
        chk("out_pc_empty", out_pc, 0);
        chk("pc4_empty", out_pc_plus_4, 4);
      end
      if (flush) begin
        q.delete();
      end else begin
        do_pop  = (sz != 0) && out_ready;
        do_push = in_valid && (sz != D);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back('{in_inst, in_pc});
      end
    end
  end

  task automatic step(bit v, logic [AW-1:0] pc, bit rdy, bit fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = {$urandom, $urandom};
    out_ready = rdy;
    flush     = fl;
  endtask

  initial begin
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_pc4", out_pc_plus_4, 4);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // First bundle with known contents
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_pc    = 10'h000;
    in_inst  = {32'h00100093, 32'h00000013};
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Fill, attempt a fifth, pop while full, then retry
    step(1, 10'h000, 0, 0);
    step(1, 10'h008, 0, 0);
    step(1, 10'h010, 0, 0);
    step(1, 10'h018, 0, 0);
    step(1, 10'h020, 0, 0);
    step(1, 10'h020, 1, 0);
    step(1, 10'h020, 1, 0);
    step(1, 10'h028, 1, 0);
    step(0, 0, 1, 0);
    repeat (6) step(0, 0, 1, 0);

    // Streaming across pointer wrap
    for (int i = 0; i < 10; i++) step(1, AW'(i * 8), 1, 0);
    repeat (3) step(0, 0, 1, 0);

    // Flush with three held
    step(1, 10'h040, 0, 0);
    step(1, 10'h048, 0, 0);
    step(1, 10'h050, 0, 0);
    step(1, 10'h100, 1, 1);
    step(1, 10'h100, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);

    // Async reset mid-cycle with two held
    step(1, 10'h060, 0, 0);
    step(1, 10'h068, 0, 0);
    step(0, 0, 0, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_stall", stall, 0);
    q.delete();
    @(negedge clk);
    #1 reset = 1'b0;
    step(1, 10'h200, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7, AW'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
    step(0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
